addsub_serial_ctrl: RTL and testbench
=====================================

// Module: addsub_serial_ctrl
// PURPOSE
//  Sequencer that performs NBYTES-wide add/subtract on the shared 8-bit
//  full_adder_8_bit_behavior datapath, one byte per cycle, LSB first, chaining carry.
//  Sits between a valid/ready request source and the adder instance.
//  Returns the wide result with carry-out and signed overflow.
// PARAMETERS
//  NBYTES  4  operand width in bytes (W = 8*NBYTES); legal range 1..16
// PORTS
//  clk            in   1   single clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   request accepted when valid&&ready at clk edge
//  req_a          in   W   operand A
//  req_b          in   W   operand B
//  req_sub        in   1   0: A+B, 1: A-B
//  rsp_valid      out  1   result present
//  rsp_ready      in   1   result consumed when valid&&ready at clk edge
//  rsp_sum        out  W   result
//  rsp_c_out      out  1   carry out of MSB byte (sub: 1 = no borrow)
//  rsp_over_flow  out  1   signed overflow of the W-bit operation
//  fa_a, fa_b     out  8   byte operands to adder
//  fa_c_in        out  1   carry into adder
//  fa_sel         out  1   adder mode: 0 = a+b+c_in, 1 = a+~b+c_in
//  fa_sum         in   8   adder sum (combinational from fa_*)
//  fa_c_out       in   1   adder carry out
//  fa_over_flow   in   1   adder signed overflow for current byte
// BEHAVIOUR
//  Reset: FSM=IDLE; req_ready=1; rsp_valid=0; rsp_sum=0; rsp_c_out=0;
//   rsp_over_flow=0; fa_a=fa_b=0; fa_c_in=0; fa_sel=0; internal regs cleared.
//  FSM IDLE -> RUN on req_valid&&req_ready: latch A, B, sub; idx=0; carry=req_sub.
//  RUN: fa_a=A[8*idx+:8], fa_b=B[8*idx+:8], fa_c_in=carry, fa_sel=sub (all from
//   regs). Each edge: result[8*idx+:8]<=fa_sum; carry<=fa_c_out; idx<=idx+1.
//   At idx==NBYTES-1 edge: also latch rsp_c_out=fa_c_out, rsp_over_flow=
//   fa_over_flow; go DONE.
//  DONE: rsp_valid=1, outputs stable; on rsp_ready -> IDLE (rsp_valid=0 next).
//  req_ready=1 only in IDLE; no overlap; throughput 1 op per NBYTES+2 cycles min.
//  Latency: rsp_valid rises exactly NBYTES clk edges after the accepting edge.
//  fa_* driven to 0 in IDLE and DONE; fa_* must not change mid-RUN-cycle.
//  Simultaneous rsp handshake and req_valid in DONE: request not accepted that
//   edge; accepted earliest on the following edge (from IDLE).
//  Carry beyond MSB byte is never wrapped into byte 0.
//  reset_n low mid-RUN or DONE: op aborted, no response, reset values at once.
//  NBYTES=1: single RUN cycle; result = adder result directly.
// CONFIGURATION
//  SAT_RESULT_EN defined: when the final rsp_over_flow=1, rsp_sum saturates to
//   A[W-1] ? {1'b1,{W-1{1'b0}}} : {1'b0,{W-1{1'b1}}}; rsp_over_flow and
//   rsp_c_out still reported unchanged. No added latency.
//  SAT_RESULT_EN undefined: rsp_sum is always the wrapped modulo-2^W result.
// TESTING  (NBYTES=4, adder model attached)
//  add 0x00000055+0x00000044 -> rsp_sum=0x00000099, c_out=0, ovf=0;
//   rsp_valid exactly 4 edges after accept.
//  add 0xFFFFFFFF+0x00000001 -> rsp_sum=0x00000000, c_out=1, ovf=0
//   (carry ripples through all 4 bytes).
//  add 0x7FFFFFFF+0x00000001 -> ovf=1; rsp_sum=0x80000000 without
//   SAT_RESULT_EN, 0x7FFFFFFF with it.
//  sub 0x00000011-0x00000055 -> rsp_sum=0xFFFFFFBC, c_out=0, ovf=0;
//   sub 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
//  Backpressure: hold rsp_ready=0 5 cycles with req_valid=1 ->
//   rsp_* stable, req_ready=0, second req accepted only after rsp handshake.
//  Pull reset_n low during RUN idx=2 -> rsp_valid=0, req_ready=1,
//   fa_*=0 immediately; next request completes correctly.

Source files
------------

// File: rtl/addsub_serial_ctrl.sv
// Byte-serial add/subtract sequencer driving an external 8-bit adder, LSB first.
// Optional macro SAT_RESULT_EN saturates the result on signed overflow.
module addsub_serial_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic                  req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_c_out,
  output logic                  rsp_over_flow,
  output logic [7:0]            fa_a,
  output logic [7:0]            fa_b,
  output logic                  fa_c_in,
  output logic                  fa_sel,
  input  logic [7:0]            fa_sum,
  input  logic                  fa_c_out,
  input  logic                  fa_over_flow
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d, merged;
  logic            sub_q, sub_d, carry_q, carry_d;
  logic            c_out_q, c_out_d, ovf_q, ovf_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            accept, last_byte;

  assign accept    = (state_q == StIdle) && req_valid;
  assign last_byte = (idx_q == LastIdx);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StRun;
      StRun:   if (last_byte) state_d = StDone;
      StDone:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    merged   = result_q;
    merged[8*idx_q +: 8] = fa_sum;
    if (accept) begin
      a_d     = req_a;
      b_d     = req_b;
      sub_d   = req_sub;
      carry_d = req_sub;
      idx_d   = '0;
    end else if (state_q == StRun) begin
      carry_d  = fa_c_out;
      idx_d    = idx_q + 1'b1;
      result_d = merged;
      if (last_byte) begin
        c_out_d = fa_c_out;
        ovf_d   = fa_over_flow;
`ifdef SAT_RESULT_EN
        // Clamp toward the sign of A; flags still report the raw outcome
        if (fa_over_flow) begin
          result_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  // Outputs: adder operands come only from registers so they hold for the whole cycle
  always_comb begin
    req_ready     = (state_q == StIdle);
    rsp_valid     = (state_q == StDone);
    rsp_sum       = result_q;
    rsp_c_out     = c_out_q;
    rsp_over_flow = ovf_q;
    fa_a          = 8'h00;
    fa_b          = 8'h00;
    fa_c_in       = 1'b0;
    fa_sel        = 1'b0;
    if (state_q == StRun) begin
      fa_a    = a_q[8*idx_q +: 8];
      fa_b    = b_q[8*idx_q +: 8];
      fa_c_in = carry_q;
      fa_sel  = sub_q;
    end
  end

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Directed bench for addsub_serial_ctrl (NBYTES=4) with a behavioural 8-bit adder attached.
module tb_addsub_serial_ctrl;

  logic        clk, reset_n;
  logic        req_valid, req_ready, req_sub;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_c_out, rsp_over_flow;
  logic [31:0] rsp_sum;
  logic [7:0]  fa_a, fa_b, fa_sum, fa_b_eff;
  logic        fa_c_in, fa_sel, fa_c_out, fa_over_flow;
  logic [8:0]  fa_wide;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  addsub_serial_ctrl #(.NBYTES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_sub       (req_sub),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_sum       (rsp_sum),
    .rsp_c_out     (rsp_c_out),
    .rsp_over_flow (rsp_over_flow),
    .fa_a          (fa_a),
    .fa_b          (fa_b),
    .fa_c_in       (fa_c_in),
    .fa_sel        (fa_sel),
    .fa_sum        (fa_sum),
    .fa_c_out      (fa_c_out),
    .fa_over_flow  (fa_over_flow)
  );

  // Adder: sel=0 a+b+c_in, sel=1 a+~b+c_in
  always_comb begin
    fa_b_eff     = fa_sel ? ~fa_b : fa_b;
    fa_wide      = {1'b0, fa_a} + {1'b0, fa_b_eff} + {8'h00, fa_c_in};
    fa_sum       = fa_wide[7:0];
    fa_c_out     = fa_wide[8];
    fa_over_flow = (fa_a[7] == fa_b_eff[7]) && (fa_wide[7] != fa_a[7]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] es, input logic ec, input logic eo);
    int cnt;
    req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check({tag, " fa_a byte0"}, 32'(fa_a), 32'(a[7:0]));
    check({tag, " fa_c_in"}, 32'(fa_c_in), 32'(sub));
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check({tag, " latency"}, 32'(cnt), 32'd4);
    check({tag, " sum"}, rsp_sum, es);
    check({tag, " c_out"}, 32'(rsp_c_out), 32'(ec));
    check({tag, " ovf"}, 32'(rsp_over_flow), 32'(eo));
    check({tag, " fa_a done"}, 32'(fa_a), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0;
    rsp_ready = 1'b0;
    #12;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_sum", rsp_sum, 32'd0);
    check("reset fa", {fa_a, fa_b, 6'd0, fa_c_in, fa_sel}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    do_op("add small", 32'h0000_0055, 32'h0000_0044, 1'b0, 32'h0000_0099, 1'b0, 1'b0);
    do_op("add ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef SAT_RESULT_EN
    do_op("add ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
`else
    do_op("add ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`endif
    do_op("sub borrow", 32'h0000_0011, 32'h0000_0055, 1'b1, 32'hFFFF_FFBC, 1'b0, 1'b0);
`ifdef SAT_RESULT_EN
    do_op("sub ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
    do_op("sub ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

    // Backpressure with a second request waiting
    req_a = 32'h0000_0100; req_b = 32'h0000_0200; req_sub = 1'b0; req_valid = 1'b1;
    step();
    req_a = 32'h0000_0003; req_b = 32'h0000_0004;
    repeat (4) step();
    check("bp rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp sum", rsp_sum, 32'h0000_0300);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp hold req_ready", 32'(req_ready), 32'd0);
      check("bp hold sum", rsp_sum, 32'h0000_0300);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp handshake rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp not yet accepted", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("bp second accepted", 32'(req_ready), 32'd0);
    repeat (4) step();
    check("bp second valid", 32'(rsp_valid), 32'd1);
    check("bp second sum", rsp_sum, 32'h0000_0007);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Abort with reset while processing byte 2
    req_a = 32'h0103_0201; req_b = 32'h0202_0202; req_sub = 1'b0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("abort fa_a idx2", 32'(fa_a), 32'h0000_0003);
    #2 reset_n = 1'b0;
    #1;
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort fa", {fa_a, fa_b, 6'd0, fa_c_in, fa_sel}, 32'd0);
    #5 reset_n = 1'b1;
    step();
    do_op("after abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
